// File: rtl/tpx3_link_status.sv
// ============================================================================
//  Module   : tpx3_link_status
//  Purpose  : Timepix3 receiver link qualification, loss counting, activity
//             stretching and LED / FMC status drive.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tpx3_link_status #(
    parameter int NUM_LINKS  = 8,
    parameter int UP_CYCLES  = 1024,
    parameter int ACT_CYCLES = 4000000,
    parameter int BLINK_BITS = 23,
    parameter int CNT_WIDTH  = 8,
    localparam int SEL_W     = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [NUM_LINKS-1:0] RX_READY,
    input  logic [NUM_LINKS-1:0] RX_DATA_VALID,
    input  logic                 ETH_STATUS_OK,
    input  logic [1:0]           MODE,
    input  logic                 CNT_CLEAR,
    input  logic [SEL_W-1:0]     CNT_SEL,
    output logic [NUM_LINKS-1:0] LINK_UP,
    output logic                 ANY_UP,
    output logic                 ALL_UP,
    output logic [CNT_WIDTH-1:0] LOSS_CNT,
    output logic [NUM_LINKS-1:0] LED,
    output logic [3:0]           FMC_LED
);

    localparam int UP_W  = (UP_CYCLES > 1) ? $clog2(UP_CYCLES) : 1;
    localparam int ACT_W = $clog2(ACT_CYCLES + 1);
    localparam logic [UP_W-1:0]  UP_LAST  = UP_W'(UP_CYCLES - 1);
    localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_CYCLES);

    logic [NUM_LINKS-1:0]  sync1_q;
    logic [NUM_LINKS-1:0]  sync2_q;
    logic [NUM_LINKS-1:0]  link_up_w;
    logic [NUM_LINKS-1:0]  act_w;
    logic [CNT_WIDTH-1:0]  loss_w [NUM_LINKS];
    logic                  any_q;
    logic                  all_q;
    logic [CNT_WIDTH-1:0]  loss_sel_q;
    logic [CNT_WIDTH-1:0]  loss_sel_d;
    logic [BLINK_BITS-1:0] blink_q;
    logic                  blink_w;
    logic [NUM_LINKS-1:0]  led_q;
    logic [NUM_LINKS-1:0]  led_d;
    logic [3:0]            fmc_q;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= RX_READY;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
        logic [UP_W-1:0]      deb_q;
        logic [UP_W-1:0]      deb_d;
        logic                 up_q;
        logic                 up_d;
        logic [CNT_WIDTH-1:0] loss_q;
        logic [CNT_WIDTH-1:0] loss_d;
        logic [ACT_W-1:0]     act_q;
        logic [ACT_W-1:0]     act_d;

        // Counter holds at UP_LAST; the up flag is raised one edge later.
        always_comb begin
            deb_d = deb_q;
            up_d  = up_q;
            if (!sync2_q[i]) begin
                deb_d = '0;
                up_d  = 1'b0;
            end else if (deb_q == UP_LAST) begin
                up_d = 1'b1;
            end else begin
                deb_d = deb_q + 1'b1;
            end

            loss_d = loss_q;
            if (CNT_CLEAR) begin
                loss_d = '0;
            end else if (up_q && !up_d && (loss_q != {CNT_WIDTH{1'b1}})) begin
                loss_d = loss_q + 1'b1;
            end

            act_d = act_q;
            if (RX_DATA_VALID[i]) begin
                act_d = ACT_LOAD;
            end else if (act_q != '0) begin
                act_d = act_q - 1'b1;
            end
        end

        always_ff @(posedge BUS_CLK) begin
            if (BUS_RST) begin
                deb_q  <= '0;
                up_q   <= 1'b0;
                loss_q <= '0;
                act_q  <= '0;
            end else begin
                deb_q  <= deb_d;
                up_q   <= up_d;
                loss_q <= loss_d;
                act_q  <= act_d;
            end
        end

        assign link_up_w[i] = up_q;
        assign act_w[i]     = (act_q != '0);
        assign loss_w[i]    = loss_q;
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        loss_sel_d = '0;
        for (int k = 0; k < NUM_LINKS; k++) begin
            if (CNT_SEL == SEL_W'(k)) begin
                loss_sel_d = loss_w[k];
            end
        end
    end

    assign blink_w = blink_q[BLINK_BITS-1];

    always_comb begin
        led_d = '0;
        case (MODE)
            2'd0:    led_d = link_up_w;
            2'd1:    led_d = act_w;
            2'd2:    led_d = link_up_w ^ (act_w & {NUM_LINKS{blink_w}});
            default: led_d = {NUM_LINKS{blink_w}};
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            any_q      <= 1'b0;
            all_q      <= 1'b0;
            loss_sel_q <= '0;
            blink_q    <= '0;
            led_q      <= '0;
            fmc_q      <= '0;
        end else begin
            any_q      <= |link_up_w;
            all_q      <= &link_up_w;
            loss_sel_q <= loss_sel_d;
            blink_q    <= blink_q + 1'b1;
            led_q      <= led_d;
            fmc_q      <= {ETH_STATUS_OK, any_q, all_q, |act_w};
        end
    end

    assign LINK_UP  = link_up_w;
    assign ANY_UP   = any_q;
    assign ALL_UP   = all_q;
    assign LOSS_CNT = loss_sel_q;
    assign LED      = led_q;
    assign FMC_LED  = fmc_q;

endmodule

`default_nettype wire
